// File: rtl/program_loader.sv
// program_loader: loads a framed host byte stream (length, payload, checksum)
// into the processor's program RAM starting at address 0, optionally zero-fills
// the remaining words, and keeps the processor in reset until a good frame lands.
module program_loader #(
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 32,
  parameter int FILL_ZERO = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wr,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  // Counter is one bit wider than the address so it can hold a length of DEPTH.
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  ONE_C   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  LAST_C  = CNT_W'(DEPTH - 1);
  localparam logic [DATA_W-1:0] DEPTH_B = DATA_W'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_CHK, S_FILL, S_DONE, S_ERR
  } state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   ptr, ptr_next, ptr_inc;
  logic [CNT_W-1:0]   len, len_next;
  logic [DATA_W-1:0]  sum, sum_next;
  logic               wr_next;
  logic [ADDR_W-1:0]  addr_next;
  logic [DATA_W-1:0]  data_next;
  logic               accept;

  // Running checksum wraps modulo 2^DATA_W.
  function automatic logic [DATA_W-1:0] csum_add(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    return a + b;
  endfunction

  assign byte_ready = (state == S_LEN) || (state == S_DATA) || (state == S_CHK);
  assign accept     = byte_valid && byte_ready;
  assign done       = (state == S_DONE);
  assign error      = (state == S_ERR);
  assign cpu_hold   = (state != S_DONE);
  assign ptr_inc    = ptr + ONE_C;

  // Next-state, write-port and frame bookkeeping decode.
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    len_next   = len;
    sum_next   = sum;
    wr_next    = 1'b0;
    addr_next  = mem_addr;
    data_next  = mem_data;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_next = S_LEN;
          sum_next   = '0;
          ptr_next   = '0;
        end
      end
      S_LEN: begin
        if (accept) begin
          len_next = CNT_W'(byte_in);
          if ((byte_in == '0) || (byte_in > DEPTH_B)) state_next = S_ERR;
          else                                        state_next = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          wr_next   = 1'b1;
          addr_next = ptr[ADDR_W-1:0];
          data_next = byte_in;
          sum_next  = csum_add(sum, byte_in);
          ptr_next  = ptr_inc;
          if (ptr_inc == len) state_next = S_CHK;
        end
      end
      S_CHK: begin
        if (accept) begin
          if (byte_in != sum)                          state_next = S_ERR;
          else if ((FILL_ZERO != 0) && (len < DEPTH_C)) state_next = S_FILL;
          else                                         state_next = S_DONE;
        end
      end
      S_FILL: begin
        wr_next   = 1'b1;
        addr_next = ptr[ADDR_W-1:0];
        data_next = '0;
        ptr_next  = ptr_inc;
        if (ptr == LAST_C) state_next = S_DONE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Control state and registered RAM write port; reset drops any pending write.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      mem_wr   <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
    end else begin
      state    <= state_next;
      mem_wr   <= wr_next;
      mem_addr <= addr_next;
      mem_data <= data_next;
    end
  end

  // Frame bookkeeping; always re-initialised on start, so no reset needed.
  always_ff @(posedge clk) begin
    ptr <= ptr_next;
    len <= len_next;
    sum <= sum_next;
  end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: frame-level model (expected write list, RAM image,
// done/error outcome) driven by directed and randomized frames.
module tb_program_loader;

  logic       clk = 1'b0;
  logic       reset, start, byte_valid;
  logic [7:0] byte_in;
  logic       byte_ready, mem_wr, cpu_hold, done, error;
  logic [4:0] mem_addr;
  logic [7:0] mem_data;

  int checks   = 0;
  int failures = 0;

  logic [12:0] exp_q[$];
  logic [7:0]  frame_q[$];
  logic [7:0]  tb_ram[32];
  logic [7:0]  exp_ram[32];

  program_loader dut (
    .clk(clk), .reset(reset), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_wr(mem_wr), .cpu_hold(cpu_hold),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] model_sum(input int first, input int n);
    int s = 0;
    for (int i = 0; i < n; i++) s = (s + int'(frame_q[first + i])) % 256;
    return 8'(s);
  endfunction

  // Per-cycle compare: every write must match the next expected write.
  always @(posedge clk) begin
    #1;
    checks++;
    if (done === 1'b1 && error === 1'b1) begin
      failures++;
      $display("FAIL done_and_error actual=11 required=not_both");
    end
    checks++;
    if (cpu_hold !== !done) begin
      failures++;
      $display("FAIL hold_vs_done cpu_hold=%b done=%b", cpu_hold, done);
    end
    if (mem_wr === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write actual=%0d:%02h required=none", mem_addr, mem_data);
      end else begin
        logic [12:0] e;
        e = exp_q.pop_front();
        if ({mem_addr, mem_data} !== e) begin
          failures++;
          $display("FAIL write actual=%0d:%02h required=%0d:%02h",
                   mem_addr, mem_data, e[12:8], e[7:0]);
        end
      end
      tb_ram[mem_addr] = mem_data;
    end
  end

  // Called at a negedge; returns at the negedge after the byte was accepted.
  // mode 0: back-to-back, 1: one idle cycle before each byte, 2: random gaps and stray starts.
  task automatic send_byte(input logic [7:0] b, input int mode);
    int guard = 0;
    if (mode == 1) begin
      byte_valid = 1'b0;
      @(negedge clk);
    end else if (mode == 2) begin
      int g = int'($urandom_range(3));
      for (int i = 0; i < g; i++) begin
        byte_valid = 1'b0;
        byte_in    = 8'($urandom_range(255));
        @(negedge clk);
      end
    end
    byte_in    = b;
    byte_valid = 1'b1;
    if (mode == 2) start = 1'($urandom_range(1));
    while (!byte_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) chk("ready_timeout", 32'(guard), 32'd0);
    @(negedge clk);
    byte_valid = 1'b0;
    start      = 1'b0;
  endtask

  // Sends frame_q as one load and checks the outcome against the frame model.
  task automatic run_frame(input int mode);
    int n, consume, w;
    bit good;
    n = int'(frame_q[0]);
    good = 1'b0;
    exp_q.delete();
    if (n == 0 || n > 32) begin
      consume = 1;
    end else begin
      for (int i = 0; i < n; i++) begin
        exp_q.push_back({5'(i), frame_q[i + 1]});
        exp_ram[i] = frame_q[i + 1];
      end
      good = (frame_q[n + 1] == model_sum(1, n));
      consume = n + 2;
      if (good)
        for (int a = n; a < 32; a++) begin
          exp_q.push_back({5'(a), 8'h00});
          exp_ram[a] = 8'h00;
        end
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_done_clr", 32'(done), 32'd0);
    chk("start_error_clr", 32'(error), 32'd0);
    chk("start_hold", 32'(cpu_hold), 32'd1);
    chk("start_ready", 32'(byte_ready), 32'd1);
    for (int i = 0; i < consume; i++) send_byte(frame_q[i], mode);
    w = 0;
    while (!(done || error) && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("frame_done", 32'(done), 32'(good));
    chk("frame_error", 32'(error), 32'(!good));
    chk("frame_hold", 32'(cpu_hold), 32'(!good));
    chk("frame_ready", 32'(byte_ready), 32'd0);
    chk("pending_writes", 32'(exp_q.size()), 32'd0);
    if (good) begin
      int bad = 0;
      for (int a = 0; a < 32; a++) if (tb_ram[a] !== exp_ram[a]) bad++;
      chk("ram_image", 32'(bad), 32'd0);
    end
    exp_q.delete();
  endtask

  task automatic load_test1();
    frame_q = '{8'h03, 8'hA0, 8'h01, 8'h1F, 8'hC0};
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(byte_ready), 32'd0);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_data", 32'(mem_data), 32'd0);
    chk("rst_hold", 32'(cpu_hold), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Test 1: basic frame with zero fill.
    for (int a = 0; a < 32; a++) tb_ram[a] = 8'hEE;
    load_test1();
    chk("model_sum_t1", 32'(model_sum(1, 3)), 32'h0C0);
    run_frame(0);
    chk("t1_ram0", 32'(tb_ram[0]), 32'h0A0);
    chk("t1_ram1", 32'(tb_ram[1]), 32'h001);
    chk("t1_ram2", 32'(tb_ram[2]), 32'h01F);
    chk("t1_ram3", 32'(tb_ram[3]), 32'h000);
    chk("t1_ram31", 32'(tb_ram[31]), 32'h000);
    chk("t1_done", 32'(done), 32'd1);

    // Test 2: illegal lengths, then recovery with a good frame.
    frame_q = '{8'h00};
    run_frame(0);
    frame_q = '{8'h21};
    run_frame(0);
    load_test1();
    run_frame(0);
    chk("t2_error_clear", 32'(error), 32'd0);

    // Test 3: bad checksum, no fill.
    frame_q = '{8'h02, 8'hFF, 8'h02, 8'h00};
    chk("model_sum_t3", 32'(model_sum(1, 2)), 32'h001);
    run_frame(0);

    // Test 4: full-depth frame, no fill cycles.
    frame_q.delete();
    frame_q.push_back(8'h20);
    for (int i = 0; i < 32; i++) frame_q.push_back(8'(i));
    chk("model_sum_t4", 32'(model_sum(1, 32)), 32'h0F0);
    frame_q.push_back(8'hF0);
    for (int a = 0; a < 32; a++) tb_ram[a] = 8'hEE;
    run_frame(0);
    chk("t4_ram31", 32'(tb_ram[31]), 32'h01F);

    // Test 5: byte_valid toggling every cycle.
    for (int a = 0; a < 32; a++) tb_ram[a] = 8'hEE;
    load_test1();
    run_frame(1);
    chk("t5_ram2", 32'(tb_ram[2]), 32'h01F);

    // Test 6: reset on the edge that accepts the 2nd data byte.
    exp_q.delete();
    exp_q.push_back({5'd0, 8'hA0});
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'h03, 0);
    send_byte(8'hA0, 0);
    byte_in = 8'h01; byte_valid = 1'b1; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; byte_valid = 1'b0;
    chk("t6_mem_wr", 32'(mem_wr), 32'd0);
    chk("t6_hold", 32'(cpu_hold), 32'd1);
    chk("t6_done", 32'(done), 32'd0);
    chk("t6_error", 32'(error), 32'd0);
    chk("t6_ready", 32'(byte_ready), 32'd0);
    chk("t6_pending", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    chk("t6_idle_ready", 32'(byte_ready), 32'd0);
    chk("t6_idle_wr", 32'(mem_wr), 32'd0);
    exp_q.delete();

    // Randomized frames: good, bad checksum, bad length, with random pacing.
    for (int f = 0; f < 24; f++) begin
      int kind, n, mode;
      kind = int'($urandom_range(9));
      mode = int'($urandom_range(2));
      n    = int'($urandom_range(32, 1));
      frame_q.delete();
      if (kind < 2) begin
        frame_q.push_back((kind == 0) ? 8'h00 : 8'(33 + $urandom_range(222)));
      end else begin
        logic [7:0] s;
        frame_q.push_back(8'(n));
        for (int i = 0; i < n; i++) frame_q.push_back(8'($urandom_range(255)));
        s = model_sum(1, n);
        if (kind < 4) s = s + 8'($urandom_range(255, 1));
        frame_q.push_back(s);
      end
      for (int a = 0; a < 32; a++) tb_ram[a] = 8'hEE;
      run_frame(mode);
    end

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
